// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - SPI master handshake and serial bus bundle
//
// Purpose : groups the transfer handshake (start/tx_data/busy/done/rx_data)
//           and the serial pins (sck/sdo/sdi, plus cs_n when chip-select
//           generation is enabled) into one bundle.
// Modports: master - the spi_master side (drives busy, done, rx_data, sck,
//                    sdo and cs_n; reads start, tx_data and sdi)
//           slave  - the user/slave side (the mirror image)
// Macro   : SPI_MASTER_CS_EN adds the active-low chip select cs_n.

interface spi_master_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sck;
    logic             sdo;
    logic             sdi;
`ifdef SPI_MASTER_CS_EN
    logic             cs_n;

    modport master (
        input  start, tx_data, sdi,
        output busy, done, rx_data, sck, sdo, cs_n
    );

    modport slave (
        output start, tx_data, sdi,
        input  busy, done, rx_data, sck, sdo, cs_n
    );
`else
    modport master (
        input  start, tx_data, sdi,
        output busy, done, rx_data, sck, sdo
    );

    modport slave (
        output start, tx_data, sdi,
        input  busy, done, rx_data, sck, sdo
    );
`endif
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, MSB first, one word per start
//
// Purpose : shifts a WIDTH-bit word out on sdo while shifting WIDTH bits in
//           from sdi. sck idles low; each half-period lasts CLK_DIV clk
//           cycles. A transfer is a LEAD half-period with sck low followed by
//           WIDTH HIGH/LOW pairs, so busy lasts (2*WIDTH+1)*CLK_DIV cycles.
// Params  : CLK_DIV (1..255) sck half-period in clk cycles
//           WIDTH   (2..32)  bits per transfer
// Ports   : clk    system clock
//           reset  asynchronous active-high reset
//           bus    spi_master_if.master (start, tx_data, busy, done, rx_data,
//                  sck, sdo, sdi and, with SPI_MASTER_CS_EN, cs_n)
// Macro   : SPI_MASTER_CS_EN enables the cs_n output (low while busy).

module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int WIDTH   = 16
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);

    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [7:0]       DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [7:0]       div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] rx_q;
    logic             sck_q;
    logic             done_q;

    // Decoded strobes from the next-state logic; the datapath acts only on
    // these so every register update is tied to a state transition.
    logic             tick;
    logic             accept;
    logic             enter_high;
    logic             enter_low;
    logic             finish;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and transition strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick       = (div_cnt == 8'd0);
        accept     = 1'b0;
        enter_high = 1'b0;
        enter_low  = 1'b0;
        finish     = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE, so a start presented
                // there is taken and transfers run back to back.
                if (bus.start) begin
                    state_d = LEAD;
                    accept  = 1'b1;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d    = HIGH;
                    enter_high = 1'b1;
                end
            end
            HIGH: begin
                if (tick) begin
                    state_d   = LOW;
                    enter_low = 1'b1;
                end
            end
            LOW: begin
                if (tick) begin
                    // bit_cnt counts sck rises already made in this transfer.
                    if (bit_cnt == LAST_BIT) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        state_d    = HIGH;
                        enter_high = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: divider, bit counter, shift registers, output flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 8'd0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;

            // Reload on every transition (and while idle) so each
            // half-period is exactly CLK_DIV cycles regardless of history.
            if ((state_d != state_q) || (state_q == IDLE)) begin
                div_cnt <= DIV_RELOAD;
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end

            if (accept) begin
                tx_sh   <= bus.tx_data;
                rx_sh   <= '0;
                bit_cnt <= '0;
            end

            // sck 0->1 edge: sample sdi in the same clk edge.
            if (enter_high) begin
                sck_q   <= 1'b1;
                rx_sh   <= {rx_sh[WIDTH-2:0], bus.sdi};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            // sck 1->0 edge: move the next tx bit onto sdo.
            if (enter_low) begin
                sck_q <= 1'b0;
                tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
            end

            // Only complete words reach rx_data; an aborted transfer
            // leaves it untouched.
            if (finish) begin
                rx_q <= rx_sh;
            end
        end
    end

`ifdef SPI_MASTER_CS_EN
    logic cs_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n_q <= 1'b1;
        end else if (accept) begin
            cs_n_q <= 1'b0;
        end else if (finish) begin
            cs_n_q <= 1'b1;
        end
    end

    assign bus.cs_n = cs_n_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
    assign bus.sck     = sck_q;
    // The MSB of the tx shifter is the bit on the wire; forced low in IDLE.
    assign bus.sdo     = (state_q != IDLE) && tx_sh[WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master at CLK_DIV 4, 2 and 1

module tb_spi_master;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_master_if #(.WIDTH(16)) if4 ();
    spi_master_if #(.WIDTH(16)) if2 ();
    spi_master_if #(.WIDTH(16)) if1 ();

    spi_master #(.CLK_DIV(4), .WIDTH(16)) u4 (.clk(clk), .reset(reset), .bus(if4));
    spi_master #(.CLK_DIV(2), .WIDTH(16)) u2 (.clk(clk), .reset(reset), .bus(if2));
    spi_master #(.CLK_DIV(1), .WIDTH(16)) u1 (.clk(clk), .reset(reset), .bus(if1));

    // Serial return path: u4 either loops sdo back or talks to a slave model.
    logic        loop4;
    logic [15:0] slave_word;
    logic [15:0] slave_bits;
    int          slave_k;

    always_comb slave_bits = slave_word << slave_k;

    assign if4.sdi = loop4 ? if4.sdo : slave_bits[15];
    assign if2.sdi = if2.sdo;
    assign if1.sdi = if1.sdo;

    // Slave presents the next bit once the previous sck rise has been seen.
    initial begin
        logic ps;
        ps      = 1'b0;
        slave_k = 0;
        forever begin
            @(negedge clk);
            if (!if4.busy) slave_k = 0;
            else if (if4.sck && !ps) slave_k = slave_k + 1;
            ps = if4.sck;
        end
    end

    typedef struct {
        logic [15:0] rx;
        logic [15:0] tx;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   sel;
    logic gap_check;

    logic        m_busy, m_done, m_sck, m_sdo, m_cs_n;
    logic [15:0] m_rx;
    int          m_div;

    always_comb begin
        m_busy = if4.busy; m_done = if4.done; m_sck = if4.sck;
        m_sdo  = if4.sdo;  m_rx   = if4.rx_data; m_div = 4; m_cs_n = 1'b1;
`ifdef SPI_MASTER_CS_EN
        m_cs_n = if4.cs_n;
`endif
        if (sel == 1) begin
            m_busy = if2.busy; m_done = if2.done; m_sck = if2.sck;
            m_sdo  = if2.sdo;  m_rx   = if2.rx_data; m_div = 2;
`ifdef SPI_MASTER_CS_EN
            m_cs_n = if2.cs_n;
`endif
        end else if (sel == 2) begin
            m_busy = if1.busy; m_done = if1.done; m_sck = if1.sck;
            m_sdo  = if1.sdo;  m_rx   = if1.rx_data; m_div = 1;
`ifdef SPI_MASTER_CS_EN
            m_cs_n = if1.cs_n;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests = n_tests + 1;
        if (act !== expv) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: follows the selected DUT, pops the scoreboard on every done.
    initial begin
        logic        p_busy, p_done, p_sck, p_rst, had_fall;
        int          busy_run, busy_len, low_run, rises, last_rise, cyc, p_sel;
        logic [15:0] sdo_word, rx_at_rise;
        exp_t        e;
        p_busy = 0; p_done = 0; p_sck = 0; p_rst = 0; had_fall = 0;
        busy_run = 0; busy_len = 0; low_run = 0; rises = 0; last_rise = 0;
        cyc = 0; p_sel = 0; sdo_word = '0; rx_at_rise = '0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (sel != p_sel) had_fall = 0;
            p_sel = sel;
            if (reset) begin
`ifdef SPI_MASTER_CS_EN
                if (!p_rst) check("cs_n_in_reset", m_cs_n, 1);
`endif
                p_busy = 0; p_done = 0; p_sck = 0; had_fall = 0;
                busy_run = 0; rises = 0; low_run = 0;
                p_rst = 1;
            end else begin
                p_rst = 0;
                if (m_busy && !p_busy) begin
                    if (gap_check && had_fall) check("busy_gap", low_run, 1);
`ifdef SPI_MASTER_CS_EN
                    check("cs_n_fall", m_cs_n, 0);
`endif
                    busy_run = 0; rises = 0; sdo_word = '0; rx_at_rise = m_rx;
                end
                if (m_busy) begin
                    busy_run = busy_run + 1;
                end else if (p_busy) begin
                    busy_len = busy_run; had_fall = 1; low_run = 1;
`ifdef SPI_MASTER_CS_EN
                    check("cs_n_rise", m_cs_n, 1);
`endif
                end else begin
                    low_run = low_run + 1;
                end
                if (m_busy && !m_done && busy_run == 33 * m_div)
                    check("rx_stable_while_busy", m_rx, rx_at_rise);
                if (m_sck && !p_sck) begin
                    if (rises > 0) check("sck_period", cyc - last_rise, 2 * m_div);
                    last_rise = cyc;
                    rises     = rises + 1;
                    sdo_word  = {sdo_word[14:0], m_sdo};
                end
                if (m_done) begin
                    check("done_after_busy_fall", {p_busy, m_busy}, 2'b10);
                    check("done_one_cycle", p_done, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", m_rx, e.rx);
                        check("sdo_bits", sdo_word, e.tx);
                        check("sck_rises", rises, 16);
                        check("busy_cycles", busy_len, e.len);
                    end
                end
                p_busy = m_busy; p_done = m_done; p_sck = m_sck;
            end
        end
    end

    task automatic drive_start(input int s, input logic st, input logic [15:0] tx);
        case (s)
            0:       begin if4.start = st; if4.tx_data = tx; end
            1:       begin if2.start = st; if2.tx_data = tx; end
            default: begin if1.start = st; if1.tx_data = tx; end
        endcase
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (m_done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic xfer(input int s, input logic [15:0] tx, input logic [15:0] rx, input bit glitch);
        exp_t e;
        e.rx = rx; e.tx = tx; e.len = 33 * m_div;
        exp_q.push_back(e);
        @(negedge clk);
        drive_start(s, 1'b1, tx);
        @(negedge clk);
        drive_start(s, 1'b0, tx);
        if (glitch) begin
            repeat (40) @(negedge clk);
            drive_start(s, 1'b1, 16'hDEAD);
            @(negedge clk);
            drive_start(s, 1'b0, 16'hDEAD);
        end
        wait_done(40 * m_div + 200);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, dones;
        reset = 1'b1; sel = 0; gap_check = 1'b0; loop4 = 1'b1; slave_word = '0;
        drive_start(0, 1'b0, '0);
        drive_start(1, 1'b0, '0);
        drive_start(2, 1'b0, '0);
        #1;
        check("reset_sck", if4.sck, 0);
        check("reset_sdo", if4.sdo, 0);
        check("reset_busy", if4.busy, 0);
        check("reset_done", if4.done, 0);
        check("reset_rx", if4.rx_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback, CLK_DIV=4
        xfer(0, 16'hA5C3, 16'hA5C3, 0);
        // Slave returns 03FF while master sends 1234
        loop4 = 1'b0; slave_word = 16'h03FF;
        xfer(0, 16'h1234, 16'h03FF, 0);
        loop4 = 1'b1;
        // Start pulsed mid-transfer must be ignored and not queued
        xfer(0, 16'h0F0F, 16'h0F0F, 1);
        repeat (200) @(negedge clk);
        check("rx_hold_idle", if4.rx_data, 16'h0F0F);

        // Reset at the 8th sck rise of a transfer: abort, no done
        @(negedge clk);
        drive_start(0, 1'b1, 16'hA5A5);
        @(negedge clk);
        drive_start(0, 1'b0, 16'hA5A5);
        rises = 0;
        begin
            logic ps;
            ps = 1'b0;
            for (int k = 0; k < 400 && rises < 8; k++) begin
                if (if4.sck && !ps) rises = rises + 1;
                ps = if4.sck;
                if (rises < 8) @(negedge clk);
            end
        end
        check("reached_8th_rise", rises, 8);
        reset = 1'b1;
        #1;
        check("abort_sck", if4.sck, 0);
        check("abort_sdo", if4.sdo, 0);
        check("abort_busy", if4.busy, 0);
        check("abort_done", if4.done, 0);
        check("abort_rx", if4.rx_data, 0);
`ifdef SPI_MASTER_CS_EN
        check("abort_cs_n", if4.cs_n, 1);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("rx_after_abort", if4.rx_data, 0);
        xfer(0, 16'hFFFF, 16'hFFFF, 0);

        // CLK_DIV=2, start held high: three back-to-back transfers
        sel = 1;
        repeat (2) @(negedge clk);
        gap_check = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.rx = 16'h5A0F; e.tx = 16'h5A0F; e.len = 66;
            exp_q.push_back(e);
        end
        @(negedge clk);
        drive_start(1, 1'b1, 16'h5A0F);
        dones = 0;
        for (int k = 0; k < 400 && dones < 3; k++) begin
            @(negedge clk);
            if (if2.done) dones = dones + 1;
        end
        drive_start(1, 1'b0, 16'h5A0F);
        check("held_start_dones", dones, 3);
        repeat (150) @(negedge clk);
        gap_check = 1'b0;

        // CLK_DIV=1 loopback
        sel = 2;
        repeat (2) @(negedge clk);
        xfer(2, 16'h8001, 16'h8001, 0);
        repeat (20) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, sets the sck half-period in clk cycles; legal range is 1..255.
REQ-002 Parameter WIDTH, default 16, sets the bits per transfer; legal range is 2..32.
REQ-003 clk  input  1  System clock; all state changes on posedge clk.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 start  input  1  Transfer request; sampled on each posedge clk.
REQ-006 tx_data  input  WIDTH  Word to transmit; captured when start is accepted.
REQ-007 busy  output  1  High while a transfer is in progress.
REQ-008 done  output  1  One-cycle pulse marking transfer completion.
REQ-009 rx_data  output  WIDTH  Last word received; valid from the done cycle onward.
REQ-010 sck  output  1  SPI clock; idles low.
REQ-011 sdo  output  1  Serial data to the slave, MSB first.
REQ-012 sdi  input  1  Serial data from the slave, MSB first.

Function
REQ-013 The SPI mode SHALL be 0: sck idles low, sdo changes only while sck is low, and sdi is sampled on the clk edge where sck is driven 0->1.
REQ-014 The state machine SHALL have four states: IDLE, LEAD, HIGH and LOW.
REQ-015 IDLE->LEAD SHALL occur on start=1; tx_data is loaded into the shift register and sdo=tx_data[WIDTH-1] from the next cycle.
REQ-016 LEAD SHALL hold sck low for CLK_DIV cycles and then go to HIGH.
REQ-017 HIGH SHALL drive sck=1 for CLK_DIV cycles and shift sdi into the receive shift LSB on HIGH entry, then go to LOW.
REQ-018 LOW SHALL drive sck=0 for CLK_DIV cycles and present the next tx bit on sdo at LOW entry.
REQ-019 After CLK_DIV cycles in LOW, the block SHALL return to HIGH while bits remain, or else go to IDLE.
REQ-020 A transfer SHALL produce exactly WIDTH rising sck edges, with a bit counter sized ceil(log2(WIDTH+1)).
REQ-021 busy SHALL be high for exactly (2*WIDTH+1)*CLK_DIV consecutive cycles, starting the cycle after start is accepted.
REQ-022 done SHALL be high for exactly one cycle, the first cycle after busy falls, and rx_data SHALL update in that same cycle.
REQ-023 rx_data SHALL hold its value between transfers, and a partial receive word SHALL never be visible on it.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 start during the done cycle SHALL be accepted, giving back-to-back transfers with a one-cycle gap.
REQ-026 sdo SHALL be 0 in IDLE.
REQ-027 The CLK_DIV cycle counter SHALL reload on every state change, with no drift across bits.
REQ-028 CLK_DIV=1 SHALL yield sck at clk/2 with the same cycle-accurate behaviour as larger values.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, sck=0, sdo=0, busy=0, done=0, rx_data=0, and clear all counters and shift registers.
REQ-030 reset asserted mid-transfer SHALL abort the transfer with no done pulse, and the partial word SHALL be discarded.
REQ-031 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-032 Macro SPI_MASTER_CS_EN SHALL control chip-select generation.
REQ-033 With SPI_MASTER_CS_EN defined, port cs_n (output, 1 bit) SHALL exist; it goes low the cycle busy rises, returns high the cycle busy falls, and resets to 1.
REQ-034 Without SPI_MASTER_CS_EN, the cs_n port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Loopback, CLK_DIV=4, WIDTH=16, sdo tied to sdi, start with tx_data=16'hA5C3 -> busy high 132 cycles, done 1 cycle, rx_data=16'hA5C3.
REQ-036 Slave model returning 16'h03FF, tx_data=16'h1234 -> sdo bit sequence 0001_0010_0011_0100 on sck rising edges, rx_data=16'h03FF, exactly 16 sck rises.
REQ-037 start held high continuously, CLK_DIV=2 -> transfers repeat with busy low exactly 1 cycle (the done cycle), and starts asserted mid-transfer are not accepted.
REQ-038 reset pulsed at the 8th sck rise -> sck=0, sdo=0, busy=0, no done pulse, rx_data unchanged at 0; a following transfer of 16'hFFFF via loopback gives rx_data=16'hFFFF.
REQ-039 CLK_DIV=1 loopback with tx_data=16'h8001 -> sck period 2 clk cycles, busy high 33 cycles, rx_data=16'h8001.
REQ-040 With SPI_MASTER_CS_EN defined -> cs_n falls with busy and rises with busy on every transfer, and cs_n=1 during reset.
